div_unit: RTL and testbench

- Iterative radix-2 restoring divider that sits in the EX stage of the 5-stage MIPS pipeline.
- Executes DIV/DIVU in place of single-cycle ALU logic.
- Produces the stall request consumed by the pipeline controller as stallreq_for_ex.
- Its 64-bit result feeds the HI/LO write path.

---
 rtl/div_unit.sv | 133 +++++++++++++
 tb/tb_div_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU in EX; raises stallreq until the
// {HI, LO} result is presented. Optional macro DIV_EARLY_OUT_EN enables the |divisor| > |dividend| shortcut.
module div_unit #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                signed_div,
   input  logic [DATA_W-1:0]   opdata1,
   input  logic [DATA_W-1:0]   opdata2,
   input  logic                annul,
   output logic [2*DATA_W-1:0] result,
   output logic                ready,
   output logic                stallreq
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   dvd_q, dvd_d;
   logic [DATA_W-1:0]   dsr_q, dsr_d;
   logic [DATA_W-1:0]   rem_q, rem_d;
   logic                qneg_q, qneg_d;
   logic                rneg_q, rneg_d;
   logic [2*DATA_W-1:0] result_q, result_d;
   logic                ready_q, ready_d;

   logic                op1_neg, op2_neg;
   logic [DATA_W-1:0]   mag1, mag2;
   logic [DATA_W:0]     trial, diff;
   logic                fits;
   logic [DATA_W-1:0]   rem_next, dvd_next, q_fix, r_fix;

   assign op1_neg = signed_div & opdata1[DATA_W-1];
   assign op2_neg = signed_div & opdata2[DATA_W-1];
   assign mag1    = op1_neg ? -opdata1 : opdata1;
   assign mag2    = op2_neg ? -opdata2 : opdata2;

   // dvd_q shifts dividend bits out at the top and quotient bits in at the bottom
   assign trial    = {rem_q, dvd_q[DATA_W-1]};
   assign diff     = trial - {1'b0, dsr_q};
   assign fits     = ~diff[DATA_W];
   assign rem_next = fits ? diff[DATA_W-1:0] : trial[DATA_W-1:0];
   assign dvd_next = {dvd_q[DATA_W-2:0], fits};
   assign q_fix    = qneg_q ? -dvd_next : dvd_next;
   assign r_fix    = rneg_q ? -rem_next : rem_next;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      dvd_d    = dvd_q;
      dsr_d    = dsr_q;
      rem_d    = rem_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      result_d = result_q;
      ready_d  = 1'b0;
      if (annul) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  if (opdata2 == '0) begin
                     state_d  = DONE;
                     result_d = {opdata1, {DATA_W{1'b1}}};
                     ready_d  = 1'b1;
`ifdef DIV_EARLY_OUT_EN
                  end else if (mag2 > mag1) begin
                     state_d  = DONE;
                     result_d = {opdata1, {DATA_W{1'b0}}};
                     ready_d  = 1'b1;
`endif
                  end else begin
                     state_d = BUSY;
                     cnt_d   = '0;
                     dvd_d   = mag1;
                     dsr_d   = mag2;
                     rem_d   = '0;
                     qneg_d  = op1_neg ^ op2_neg;
                     rneg_d  = op1_neg;
                  end
               end
            end
            BUSY: begin
               dvd_d = dvd_next;
               rem_d = rem_next;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(DATA_W - 1)) begin
                  state_d  = DONE;
                  result_d = {r_fix, q_fix};
                  ready_d  = 1'b1;
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         dvd_q    <= '0;
         dsr_q    <= '0;
         rem_q    <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         result_q <= '0;
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         dvd_q    <= dvd_d;
         dsr_q    <= dsr_d;
         rem_q    <= rem_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         result_q <= result_d;
         ready_q  <= ready_d;
      end
   end

   assign result   = result_q;
   assign ready    = ready_q;
   // Combinational so the stall drops in the same cycle the result appears
   assign stallreq = start & ~ready_q & ~annul & ~rst;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: drivers push expected {HI, LO} into exp_q, a monitor
// pops on every ready pulse. Honours DIV_EARLY_OUT_EN for expected latency.
module tb_div_unit;
   localparam int W = 32;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start = 1'b0;
   logic           signed_div = 1'b0;
   logic [W-1:0]   opdata1 = '0;
   logic [W-1:0]   opdata2 = '0;
   logic           annul = 1'b0;
   logic [2*W-1:0] result;
   logic           ready;
   logic           stallreq;

   logic [2*W-1:0] exp_q[$];
   int tests = 0;
   int fails = 0;

   div_unit #(.DATA_W(W), .CNT_W(6)) dut (
      .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
      .opdata1(opdata1), .opdata2(opdata2), .annul(annul),
      .result(result), .ready(ready), .stallreq(stallreq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference model: plain integer division (truncating) on sign- or zero-extended values
   function automatic logic [2*W-1:0] model(input logic sd, input logic [W-1:0] a, input logic [W-1:0] b);
      longint sa, sb, q, r;
      logic [W-1:0] qq, rr;
      if (b == '0) return {a, {W{1'b1}}};
      sa = sd ? longint'($signed(a)) : longint'(a);
      sb = sd ? longint'($signed(b)) : longint'(b);
      q  = sa / sb;
      r  = sa % sb;
      qq = q[W-1:0];
      rr = r[W-1:0];
      return {rr, qq};
   endfunction

   function automatic int exp_lat(input logic sd, input logic [W-1:0] a, input logic [W-1:0] b);
      longint ma, mb;
      ma = (sd && a[W-1]) ? -longint'($signed(a)) : longint'(a);
      mb = (sd && b[W-1]) ? -longint'($signed(b)) : longint'(b);
      if (b == '0) return 1;
`ifdef DIV_EARLY_OUT_EN
      if (mb > ma) return 1;
`endif
      return W + 1;
   endfunction

   task automatic start_op(input logic sd, input logic [W-1:0] a, input logic [W-1:0] b);
      @(posedge clk); #1;
      start = 1'b1; signed_div = sd; opdata1 = a; opdata2 = b;
   endtask

   // Issues one op (start left high) and checks stall profile and latency
   task automatic run_div(input logic sd, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp, input string name);
      int n;
      logic stall_bad;
      start_op(sd, a, b);
      exp_q.push_back(exp);
      n = 0;
      stall_bad = 1'b0;
      forever begin
         @(negedge clk);
         if (ready === 1'b1) break;
         if (stallreq !== 1'b1) stall_bad = 1'b1;
         n++;
         if (n > 200) break;
      end
      chk({name, "_latency"}, 64'(n), 64'(exp_lat(sd, a, b)));
      chk({name, "_stall_busy"}, 64'(stall_bad), 64'd0);
      chk({name, "_stall_done"}, 64'(stallreq), 64'd0);
   endtask

   task automatic idle(input int n);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (n) @(posedge clk);
   endtask

   always @(negedge clk) begin
      if (ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_ready: got result %h, expected no result", result);
         end else begin
            chk("result", result, exp_q.pop_front());
         end
      end
   end

   initial begin
      logic bad;
      logic sd;
      logic [W-1:0] a, b;
      // Reset state, with start high to show the stall is masked
      start = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_result", result, '0);
      chk("reset_ready", 64'(ready), 64'd0);
      chk("reset_stall", 64'(stallreq), 64'd0);
      start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      idle(1);

      run_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, "divu_100_7");
      idle(1);
      run_div(1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, "div_m7_2");
      idle(1);
      run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, "div_ovf");
      idle(1);
      run_div(1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFFFFFF}, "divu_5_0");
      idle(1);
      run_div(1'b0, 32'd3, 32'd10, {32'd3, 32'd0}, "divu_3_10");
      idle(1);

      // Annul in cycle 10 of a 1000/3
      start_op(1'b0, 32'd1000, 32'd3);
      repeat (10) @(posedge clk);
      #1 annul = 1'b1;
      @(negedge clk);
      chk("annul_stall", 64'(stallreq), 64'd0);
      @(posedge clk); #1;
      annul = 1'b0;
      start = 1'b0;
      bad = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (ready !== 1'b0) bad = 1'b1;
      end
      chk("annul_no_ready", 64'(bad), 64'd0);
      run_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, "divu_9_3");

      // Back-to-back with start held
      run_div(1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, "b2b_50_5");
      run_div(1'b0, 32'd7, 32'd2, {32'd1, 32'd3}, "b2b_7_2");
      idle(1);

      // Asynchronous reset mid-BUSY, between edges of cycle 15
      start_op(1'b0, 32'd1000, 32'd3);
      repeat (15) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("arst_result", result, '0);
      chk("arst_ready", 64'(ready), 64'd0);
      chk("arst_stall", 64'(stallreq), 64'd0);
      start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      idle(1);
      run_div(1'b0, 32'd20, 32'd4, {32'd0, 32'd5}, "divu_20_4");
      idle(1);

      // Randomized operations against the reference model
      for (int i = 0; i < 40; i++) begin
         sd = 1'($urandom_range(0, 1));
         a  = $urandom;
         case ($urandom_range(0, 5))
            0:       b = '0;
            1:       b = 32'd1;
            2:       b = 32'hFFFFFFFF;
            3:       b = 32'($urandom_range(2, 300));
            4:       b = a + 32'd1;
            default: b = $urandom;
         endcase
         if ($urandom_range(0, 3) == 0) a = 32'h80000000;
         run_div(sd, a, b, model(sd, a, b), "rand");
         if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 2));
      end
      idle(3);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
